image_mem_reader: RTL and testbench

IMAGE_MEM_READER -- requirements
Module: image_mem_reader

---
 rtl/mem_config_pkg.sv | 7 +
 rtl/sobel_config_pkg.sv | 17 +
 rtl/reader_fifo2.sv | 57 +++++
 rtl/image_mem_reader.sv | 151 +++++++++++++++
 tb/tb_image_mem_reader.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_config_pkg.sv
// Shared memory geometry for the image BRAM and its readers.
package mem_config_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 8;

endpackage

// File: rtl/sobel_config_pkg.sv
// Sobel pipeline configuration: reader FSM states and the pixel FIFO entry layout.
package sobel_config_pkg;

  import mem_config_pkg::*;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } reader_state_e;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } pix_entry_t;

endpackage

// File: rtl/reader_fifo2.sv
// Two-entry FIFO with push/pop/count; a simultaneous push and pop leaves the count unchanged.
module reader_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [1:0]       count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != 2'd0);
    do_push  = push_i && ((count_q != 2'd2) || do_pop);
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
    end
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/image_mem_reader.sv
// Streams NUM_PIXELS words out of a 1-cycle-latency image BRAM as a valid/ready pixel stream.
// Optional feature: define IMG_READER_STALL_CNT_EN to add the stall_cnt_o backpressure counter.
module image_mem_reader
  import mem_config_pkg::*;
  import sobel_config_pkg::*;
#(
  parameter int NUM_PIXELS = 2**ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
  output logic [DATA_WIDTH-1:0] pix_data_o,
  output logic                  pix_valid_o,
  input  logic                  pix_ready_i,
  output logic                  pix_last_o
`ifdef IMG_READER_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt_o
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);

  reader_state_e         state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  all_issued_q, all_issued_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;

  pix_entry_t            fifo_wdata;
  pix_entry_t            fifo_head;
  logic [1:0]            fifo_count;
  logic                  fifo_empty;
  logic                  pop;
  logic                  issue;
  logic [2:0]            credit_sum;

  assign fifo_wdata = '{last: inflight_last_q, data: mem_rd_data_i};

  reader_fifo2 #(
    .WIDTH($bits(pix_entry_t))
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (inflight_q),
    .pop_i  (pop),
    .wdata_i(fifo_wdata),
    .rdata_o(fifo_head),
    .count_o(fifo_count),
    .empty_o(fifo_empty)
  );

  assign pix_valid_o = !fifo_empty;
  assign pix_data_o  = pix_valid_o ? fifo_head.data : '0;
  assign pix_last_o  = pix_valid_o && fifo_head.last;
  assign pop         = pix_valid_o && pix_ready_i;

  // Credit counts words already buffered plus the one still in the BRAM pipe, so the FIFO never overflows.
  assign credit_sum = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue      = (state_q == RUN) && !all_issued_q && (credit_sum < 3'd2);

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    all_issued_d    = all_issued_q;
    inflight_d      = issue;
    inflight_last_d = issue && (addr_q == LAST_ADDR);
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d      = RUN;
          addr_d       = '0;
          all_issued_d = 1'b0;
        end
      end
      RUN: begin
        if (issue) begin
          if (addr_q == LAST_ADDR) begin
            all_issued_d = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
        if (pop && fifo_head.last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        addr_d  = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      addr_q          <= '0;
      all_issued_q    <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      addr_q          <= addr_d;
      all_issued_q    <= all_issued_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign mem_addr_o = addr_q;

`ifdef IMG_READER_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == IDLE) && start_i) begin
      stall_cnt_d = '0;
    end else if (pix_valid_o && !pix_ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_image_mem_reader.sv
// Randomised bench for image_mem_reader against a frame-level pixel model (NUM_PIXELS=8, mem[i]=0x10+i).
module tb_image_mem_reader;

  import mem_config_pkg::*;

  localparam int NPIX = 8;

  logic                  clk_i;
  logic                  rst_ni;
  logic                  start_i;
  logic                  busy_o;
  logic                  done_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_rd_data_i;
  logic [DATA_WIDTH-1:0] pix_data_o;
  logic                  pix_valid_o;
  logic                  pix_ready_i;
  logic                  pix_last_o;
`ifdef IMG_READER_STALL_CNT_EN
  logic [31:0]           stall_cnt_o;
  int                    stall_in_frame;
`endif

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  int                    n_checks;
  int                    n_fail;
  int                    exp_idx;
  int                    hs_in_frame;
  int                    frames_done;
  bit                    prev_stall;
  bit                    prev_last_hs;
  logic [DATA_WIDTH-1:0] prev_data;
  logic                  prev_last;

  image_mem_reader #(
    .NUM_PIXELS(NPIX)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .mem_addr_o   (mem_addr_o),
    .mem_rd_data_i(mem_rd_data_i),
    .pix_data_o   (pix_data_o),
    .pix_valid_o  (pix_valid_o),
    .pix_ready_i  (pix_ready_i),
    .pix_last_o   (pix_last_o)
`ifdef IMG_READER_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Image BRAM: registered read, one cycle of latency.
  always @(posedge clk_i) begin
    mem_rd_data_i <= mem[mem_addr_o];
  end

  function automatic logic [DATA_WIDTH-1:0] refPixel(input int idx);
    return DATA_WIDTH'(16 + idx);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Frame-level model: every handshake must carry the next pixel in address order, and done follows the last one.
  task automatic runMonitor();
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        exp_idx      = 0;
        hs_in_frame  = 0;
        prev_stall   = 1'b0;
        prev_last_hs = 1'b0;
`ifdef IMG_READER_STALL_CNT_EN
        stall_in_frame = 0;
`endif
      end else begin
        checkOutput("done_o", 32'(done_o), 32'(prev_last_hs));
        if (done_o) begin
          checkOutput("busy_in_done", 32'(busy_o), 32'd0);
          checkOutput("frame_len", 32'(hs_in_frame), 32'(NPIX));
`ifdef IMG_READER_STALL_CNT_EN
          checkOutput("stall_cnt", stall_cnt_o, 32'(stall_in_frame));
          stall_in_frame = 0;
`endif
          frames_done++;
          hs_in_frame = 0;
          exp_idx     = 0;
        end
        if (prev_stall) begin
          checkOutput("hold_valid", 32'(pix_valid_o), 32'd1);
          checkOutput("hold_data", 32'(pix_data_o), 32'(prev_data));
          checkOutput("hold_last", 32'(pix_last_o), 32'(prev_last));
        end
        if (pix_valid_o) begin
          checkOutput("busy_with_valid", 32'(busy_o), 32'd1);
        end
        prev_last_hs = 1'b0;
        if (pix_valid_o && pix_ready_i) begin
          checkOutput("pix_data", 32'(pix_data_o), 32'(refPixel(exp_idx)));
          checkOutput("pix_last", 32'(pix_last_o), 32'(exp_idx == NPIX - 1));
          prev_last_hs = (exp_idx == NPIX - 1);
          exp_idx++;
          hs_in_frame++;
        end
`ifdef IMG_READER_STALL_CNT_EN
        if (pix_valid_o && !pix_ready_i) begin
          stall_in_frame++;
        end
`endif
        prev_stall = pix_valid_o && !pix_ready_i;
        prev_data  = pix_data_o;
        prev_last  = pix_last_o;
      end
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy_o), 32'd0);
    checkOutput({tag, "_done"}, 32'(done_o), 32'd0);
    checkOutput({tag, "_valid"}, 32'(pix_valid_o), 32'd0);
    checkOutput({tag, "_last"}, 32'(pix_last_o), 32'd0);
    checkOutput({tag, "_data"}, 32'(pix_data_o), 32'd0);
    checkOutput({tag, "_addr"}, 32'(mem_addr_o), 32'd0);
  endtask

  // Runs one frame. mode: 0 ready high, 1 ready low for stream cycles 3-6, 2 toggling, 3 random.
  task automatic applyStimulus(input int mode, input bit start_hold, input bit poke_start);
    bit got_done;
    int done_j;
    got_done    = 1'b0;
    done_j      = 0;
    start_i     = 1'b1;
    pix_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    if (!start_hold) start_i = 1'b0;
    for (int j = 0; j < 100; j++) begin
      case (mode)
        1:       pix_ready_i = !((j >= 5) && (j <= 8));
        2:       pix_ready_i = j[0];
        3:       pix_ready_i = ($urandom_range(0, 3) != 0);
        default: pix_ready_i = 1'b1;
      endcase
      if (poke_start && !start_hold) start_i = (j == 5);
      @(negedge clk_i);
      if (j == 0) begin
        checkOutput("addr_start", 32'(mem_addr_o), 32'd0);
        checkOutput("busy_run", 32'(busy_o), 32'd1);
        checkOutput("valid_at_0", 32'(pix_valid_o), 32'd0);
`ifdef IMG_READER_STALL_CNT_EN
        checkOutput("stall_cleared", stall_cnt_o, 32'd0);
`endif
      end
      if (j == 1) checkOutput("valid_at_1", 32'(pix_valid_o), 32'd0);
      if (j == 2) checkOutput("valid_at_2", 32'(pix_valid_o), 32'd1);
      if (done_o) begin
        got_done = 1'b1;
        done_j   = j;
        break;
      end
      @(posedge clk_i);
      #1;
    end
    checkOutput("frame_done_seen", 32'(got_done), 32'd1);
    if (mode == 0) checkOutput("done_cycle", 32'(done_j), 32'd10);
`ifdef IMG_READER_STALL_CNT_EN
    if (mode == 1) checkOutput("stall_cnt_window", stall_cnt_o, 32'd4);
`endif
    if (poke_start) start_i = 1'b1;
    @(posedge clk_i);
    #1;
    if (!start_hold) start_i = 1'b0;
    pix_ready_i = 1'b1;
  endtask

  task automatic idleCheck(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk_i);
      checkOutput("idle_busy", 32'(busy_o), 32'd0);
      checkOutput("idle_valid", 32'(pix_valid_o), 32'd0);
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic resetMidFrame();
    start_i     = 1'b1;
    pix_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (hs_in_frame >= 3) break;
      @(posedge clk_i);
      #1;
    end
    checkOutput("hs_before_reset", 32'(hs_in_frame), 32'd3);
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni  = 1'b1;
    start_i = 1'b1;
    @(negedge clk_i);
    checkResetValues("midreset");
    applyStimulus(0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    exp_idx      = 0;
    hs_in_frame  = 0;
    frames_done  = 0;
    prev_stall   = 1'b0;
    prev_last_hs = 1'b0;
    prev_data    = '0;
    prev_last    = 1'b0;
`ifdef IMG_READER_STALL_CNT_EN
    stall_in_frame = 0;
`endif
    for (int i = 0; i < 2**ADDR_WIDTH; i++) begin
      mem[i] = DATA_WIDTH'(16 + i);
    end
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    pix_ready_i = 1'b0;
    fork
      runMonitor();
    join_none

    repeat (2) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    checkResetValues("reset");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idleCheck(2);

    $display("[TB] basic frame, ready high");
    applyStimulus(0, 1'b0, 1'b0);
    idleCheck(2);

    $display("[TB] ready low for stream cycles 3-6");
    applyStimulus(1, 1'b0, 1'b0);
    idleCheck(1);

    $display("[TB] ready toggling");
    applyStimulus(2, 1'b0, 1'b0);
    idleCheck(1);

    $display("[TB] start held high, back-to-back frames");
    applyStimulus(0, 1'b1, 1'b0);
    applyStimulus(2, 1'b1, 1'b0);
    start_i = 1'b0;
    idleCheck(3);

    $display("[TB] start pulsed in RUN and DONE");
    applyStimulus(0, 1'b0, 1'b1);
    idleCheck(4);

    $display("[TB] reset after third handshake");
    resetMidFrame();
    idleCheck(2);

    $display("[TB] random backpressure frames");
    for (int f = 0; f < 4; f++) begin
      applyStimulus(3, 1'b0, 1'b0);
      idleCheck($urandom_range(1, 3));
    end

    checkOutput("frames_total", 32'(frames_done), 32'd11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
